// File: rtl/vin_capture.sv
// -----------------------------------------------------------------------------
// vin_capture
// Receives the raw video timing interface (vsync / hsync / de / 8-bit pixel),
// checks the frame geometry against the configured active size, packs pairs of
// 8-bit pixels into 16-bit words and pushes them out over a valid/ready
// handshake. The measured geometry and sticky error flags go to the debug core.
//
// Ports
//   clk          pixel clock, same domain as the v_* inputs
//   rst          synchronous, active-high reset
//   v_vsync      vertical sync, active high (frame starts on its rising edge)
//   v_hsync      horizontal sync, informational only
//   v_de         data enable, active high (line ends on its falling edge)
//   v_pixel      8-bit pixel, valid while v_de = 1
//   out_pixel    packed word: [7:0] = even pixel, [15:8] = odd pixel
//   out_valid    out_pixel holds a word
//   out_ready    downstream takes the word when out_valid & out_ready
//   frame_start  one-cycle pulse per vsync rising edge
//   meas_h       pixel count of the last completed line
//   meas_v       line count of the last completed frame
//   err_hact     sticky: a line length differed from H_ACT
//   err_vact     sticky: a frame line count differed from V_ACT
//   err_ovf      sticky: a packed word was dropped while the output stalled
//   err_clr      clears all sticky flags (a same-cycle error still sets them)
//
// H_ACT must be even so that each good line packs into whole words.
// -----------------------------------------------------------------------------
module vin_capture #(
    parameter int H_ACT = 800,
    parameter int V_ACT = 1200,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_vsync,
    input  logic             v_hsync,
    input  logic             v_de,
    input  logic [7:0]       v_pixel,
    output logic [15:0]      out_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_start,
    output logic [CNT_W-1:0] meas_h,
    output logic [CNT_W-1:0] meas_v,
    output logic             err_hact,
    output logic             err_vact,
    output logic             err_ovf,
    input  logic             err_clr
);

    typedef enum logic [0:0] {
        S_WAIT  = 1'b0,
        S_FRAME = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] H_LIM   = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_LIM   = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Input stage and its one-cycle-delayed copy for edge detection.
    logic             r_vs;
    logic             r_vs_d;
    logic             r_de;
    logic             r_de_d;
    logic [7:0]       r_pix;

    // Frame tracking.
    state_t           r_state;
    state_t           w_state_next;
    logic             r_first;
    logic             r_skip;
    logic             r_phase;
    logic [7:0]       r_low;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_line_cnt;

    // Output registers.
    logic [15:0]      r_out_pixel;
    logic             r_out_valid;
    logic             r_frame_start;
    logic [CNT_W-1:0] r_meas_h;
    logic [CNT_W-1:0] r_meas_v;
    logic             r_err_hact;
    logic             r_err_vact;
    logic             r_err_ovf;

    // Decoded per-cycle controls.
    logic             w_vs_rise;
    logic             w_de_fall;
    logic             w_live;
    logic             w_line_end;
    logic             w_de_cnt;
    logic             w_over_v;
    logic             w_accept;
    logic             w_word_done;
    logic             w_hs;
    logic             w_load;
    logic             w_drop;
    logic             w_frame_chk;
    logic             w_hact_bad;
    logic [15:0]      w_word;

    // hsync carries no information this block needs; line end comes from de.
    logic             w_unused_hsync;
    assign w_unused_hsync = v_hsync;

    // Register the video inputs one stage and keep the previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
            r_de   <= 1'b0;
            r_de_d <= 1'b0;
            r_pix  <= 8'h00;
        end else begin
            r_vs   <= v_vsync;
            r_vs_d <= r_vs;
            r_de   <= v_de;
            r_de_d <= r_de;
            r_pix  <= v_pixel;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave S_WAIT on the first vsync rising edge, then stay framed.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT: begin
                if (w_vs_rise) begin
                    w_state_next = S_FRAME;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_FRAME: w_state_next = S_FRAME;
            default: w_state_next = S_WAIT;
        endcase
    end

    // Per-cycle control decode from the registered inputs and counters.
    always_comb begin
        w_vs_rise   = r_vs & ~r_vs_d;
        w_de_fall   = ~r_de & r_de_d;
        // vsync takes priority; a line cut by vsync is ignored until de drops.
        w_live      = (r_state == S_FRAME) & ~w_vs_rise & ~r_skip;
        w_line_end  = w_live & w_de_fall;
        w_de_cnt    = w_live & r_de;
        w_over_v    = w_de_cnt & (r_line_cnt >= V_LIM);
        w_accept    = w_de_cnt & (r_line_cnt < V_LIM) & (r_pix_cnt < H_LIM);
        w_word_done = w_accept & r_phase;
        w_word      = {r_pix, r_low};
        w_hs        = r_out_valid & out_ready;
        // A completing word may load when the register is empty or draining.
        w_load      = w_word_done & (~r_out_valid | out_ready);
        w_drop      = w_word_done & r_out_valid & ~out_ready;
        w_frame_chk = w_vs_rise & ~r_first & (r_line_cnt != V_LIM);
        w_hact_bad  = w_line_end & (r_pix_cnt != H_LIM);
    end

    // Pixel/line counters, pack phase and the first-frame / skip flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt  <= CNT_ZERO;
            r_line_cnt <= CNT_ZERO;
            r_phase    <= 1'b0;
            r_low      <= 8'h00;
            r_first    <= 1'b1;
            r_skip     <= 1'b0;
        end else begin
            if (w_vs_rise) begin
                r_pix_cnt  <= CNT_ZERO;
                r_line_cnt <= CNT_ZERO;
                r_phase    <= 1'b0;
                r_first    <= 1'b0;
            end else if (w_line_end) begin
                r_pix_cnt  <= CNT_ZERO;
                r_line_cnt <= sat_inc(r_line_cnt);
                r_phase    <= 1'b0;
            end else if (w_de_cnt) begin
                r_pix_cnt <= sat_inc(r_pix_cnt);
                if (w_accept) begin
                    r_phase <= ~r_phase;
                end else begin
                    r_phase <= r_phase;
                end
            end else begin
                r_pix_cnt <= r_pix_cnt;
            end

            if (w_accept && !r_phase) begin
                r_low <= r_pix;
            end else begin
                r_low <= r_low;
            end

            // A vsync arriving while de is high leaves the rest of that line dead.
            if (w_vs_rise) begin
                r_skip <= r_de;
            end else if (!r_de) begin
                r_skip <= 1'b0;
            end else begin
                r_skip <= r_skip;
            end
        end
    end

    // Output word register, frame pulse and geometry measurements.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_pixel   <= 16'h0000;
            r_out_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_meas_h      <= CNT_ZERO;
            r_meas_v      <= CNT_ZERO;
        end else begin
            r_frame_start <= w_vs_rise;

            if (w_vs_rise) begin
                r_meas_v <= r_line_cnt;
            end else begin
                r_meas_v <= r_meas_v;
            end

            if (w_line_end) begin
                r_meas_h <= r_pix_cnt;
            end else begin
                r_meas_h <= r_meas_h;
            end

            if (w_load) begin
                r_out_pixel <= w_word;
                r_out_valid <= 1'b1;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_hact <= 1'b0;
            r_err_vact <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            r_err_hact <= (r_err_hact & ~err_clr) | w_hact_bad;
            r_err_vact <= (r_err_vact & ~err_clr) | w_frame_chk | w_over_v;
            r_err_ovf  <= (r_err_ovf & ~err_clr) | w_drop;
        end
    end

    assign out_pixel   = r_out_pixel;
    assign out_valid   = r_out_valid;
    assign frame_start = r_frame_start;
    assign meas_h      = r_meas_h;
    assign meas_v      = r_meas_v;
    assign err_hact    = r_err_hact;
    assign err_vact    = r_err_vact;
    assign err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_vin_capture.sv
// -----------------------------------------------------------------------------
// tb_vin_capture
// Drives vin_capture with H_ACT=8, V_ACT=4 through directed scenarios and then
// randomized frames. A frame/line-level reference model inside the bench
// predicts every output; one compare process checks all outputs on every
// falling clock edge, and directed literal checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_vin_capture;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 12;
    localparam int SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          v_vsync;
    logic          v_hsync;
    logic          v_de;
    logic [7:0]    v_pixel;
    logic [15:0]   out_pixel;
    logic          out_valid;
    logic          out_ready;
    logic          frame_start;
    logic [CW-1:0] meas_h;
    logic [CW-1:0] meas_v;
    logic          err_hact;
    logic          err_vact;
    logic          err_ovf;
    logic          err_clr;

    vin_capture #(.H_ACT(H), .V_ACT(V), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .v_vsync     (v_vsync),
        .v_hsync     (v_hsync),
        .v_de        (v_de),
        .v_pixel     (v_pixel),
        .out_pixel   (out_pixel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_start (frame_start),
        .meas_h      (meas_h),
        .meas_v      (meas_v),
        .err_hact    (err_hact),
        .err_vact    (err_vact),
        .err_ovf     (err_ovf),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, in terms of frames, lines and pixel pairs.
    bit            m_framed;
    bit            m_first;
    bit            m_line_dead;
    int            m_lines;
    int            m_pixn;
    logic [7:0]    m_pair[$];
    logic [15:0]   m_words[$];
    // Pin samples as the block sees them: one cycle old and two cycles old.
    bit            s1_vs, s0_vs, s1_de, s0_de;
    logic [7:0]    s1_px;
    // Expected outputs.
    logic          e_valid, e_fs, e_eh, e_ev, e_eo;
    logic [15:0]   e_word;
    logic [CW-1:0] e_mh, e_mv;

    logic [15:0]   d_words[$];
    int            d_fs;
    bit            rand_mode;
    bit            cmp_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the pins seen at that edge.
    task automatic model_edge();
        bit          rise;
        bit          fall;
        bit          have_word;
        logic [15:0] w;
        if (rst) begin
            m_framed = 0; m_first = 1; m_line_dead = 0;
            m_lines = 0; m_pixn = 0; m_pair.delete();
            s1_vs = 0; s0_vs = 0; s1_de = 0; s0_de = 0; s1_px = 8'h00;
            e_valid = 0; e_fs = 0; e_eh = 0; e_ev = 0; e_eo = 0;
            e_word = 16'h0000; e_mh = '0; e_mv = '0;
        end else begin
            rise = s1_vs && !s0_vs;
            fall = !s1_de && s0_de;
            have_word = 0;
            w = 16'h0000;
            if (e_valid && out_ready) m_words.push_back(e_word);
            if (err_clr) begin
                e_eh = 0; e_ev = 0; e_eo = 0;
            end
            e_fs = rise;
            if (rise) begin
                e_mv = CW'(m_lines);
                if (!m_first && m_lines != V) e_ev = 1;
                m_lines = 0; m_pixn = 0; m_pair.delete();
                m_first = 0; m_framed = 1;
                m_line_dead = s1_de;
            end else if (m_framed) begin
                if (m_line_dead) begin
                    if (!s1_de) m_line_dead = 0;
                end else if (fall) begin
                    e_mh = CW'(m_pixn);
                    if (m_pixn != H) e_eh = 1;
                    m_pair.delete();
                    m_lines = (m_lines < SAT) ? m_lines + 1 : SAT;
                    m_pixn = 0;
                end else if (s1_de) begin
                    if (m_lines >= V) begin
                        e_ev = 1;
                    end else if (m_pixn < H) begin
                        m_pair.push_back(s1_px);
                        if (m_pair.size() == 2) begin
                            w = {m_pair[1], m_pair[0]};
                            m_pair.delete();
                            have_word = 1;
                        end
                    end
                    m_pixn = (m_pixn < SAT) ? m_pixn + 1 : SAT;
                end
            end
            if (have_word) begin
                if (!e_valid || out_ready) begin
                    e_valid = 1;
                    e_word = w;
                end else begin
                    e_eo = 1;
                end
            end else if (e_valid && out_ready) begin
                e_valid = 0;
            end
            s0_vs = s1_vs; s0_de = s1_de;
            s1_vs = v_vsync; s1_de = v_de; s1_px = v_pixel;
        end
    endtask

    // One pixel-clock cycle of stimulus.
    task automatic step(input bit vs, input bit de, input logic [7:0] px);
        v_vsync = vs;
        v_de    = de;
        v_hsync = ~de;
        v_pixel = px;
        if (rand_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 31) == 0);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vsync_pulse();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        gap(2);
    endtask

    // A line of n pixels base, base+1, ...; vsync may be raised at pixel vs_at.
    task automatic line(input int n, input int base, input int vs_at);
        for (int i = 0; i < n; i++)
            step((vs_at >= 0) && (i >= vs_at) && (i < vs_at + 2), 1'b1, 8'(base + i));
        gap(3);
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
    endtask

    // Compare every output with the model on each falling edge.
    initial begin
        wait (cmp_en);
        forever begin
            @(negedge clk);
            chk("out_valid",   out_valid,   e_valid);
            chk("out_pixel",   out_pixel,   e_word);
            chk("frame_start", frame_start, e_fs);
            chk("meas_h",      meas_h,      e_mh);
            chk("meas_v",      meas_v,      e_mv);
            chk("err_hact",    err_hact,    e_eh);
            chk("err_vact",    err_vact,    e_ev);
            chk("err_ovf",     err_ovf,     e_eo);
            if (out_valid === 1'b1 && out_ready === 1'b1) d_words.push_back(out_pixel);
            if (frame_start === 1'b1) d_fs++;
        end
    end

    initial begin
        int k;
        int nl;
        int len;
        int vs_at;
        rand_mode = 0; cmp_en = 0; d_fs = 0;
        rst = 1'b1; out_ready = 1'b1; err_clr = 1'b0;
        v_vsync = 1'b0; v_hsync = 1'b1; v_de = 1'b0; v_pixel = 8'h00;
        step(1'b0, 1'b0, 8'h00);
        cmp_en = 1;
        gap(2);
        rst = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_pixel", out_pixel, 16'h0000);
        chk("rst_meas_v", meas_v, 12'd0);
        chk("rst_errs", {err_hact, err_vact, err_ovf}, 3'b000);

        // de activity before any vsync is ignored.
        line(8, 8'h40, -1);
        line(8, 8'h50, -1);
        chk("pre_vsync_words", d_words.size(), 0);
        chk("pre_vsync_errs", {err_hact, err_vact, err_ovf}, 3'b000);

        // Two good frames, pixel value = index within the frame.
        d_words.delete(); m_words.delete(); d_fs = 0;
        vsync_pulse();
        for (int l = 0; l < V; l++) line(H, l * H, -1);
        chk("f1_words", d_words.size(), 16);
        chk("f1_word0", d_words[0], 16'h0100);
        chk("f1_word1", d_words[1], 16'h0302);
        chk("f1_word15", d_words[15], 16'h1F1E);
        chk("model_word0", m_words[0], 16'h0100);
        chk("f1_meas_h", meas_h, 12'd8);
        vsync_pulse();
        chk("f1_meas_v", meas_v, 12'd4);
        for (int l = 0; l < V; l++) line(H, 32 + l * H, -1);
        chk("f2_words", d_words.size(), 32);
        chk("model_words", m_words.size(), 32);
        chk("f2_frame_starts", d_fs, 2);
        chk("f2_errs", {err_hact, err_vact, err_ovf}, 3'b000);

        // Short line of 6 pixels.
        vsync_pulse();
        chk("f2_meas_v", meas_v, 12'd4);
        line(H, 0, -1);
        k = d_words.size();
        line(6, 8'h10, -1);
        chk("short_words", d_words.size() - k, 3);
        chk("short_err_hact", err_hact, 1'b1);
        chk("short_meas_h", meas_h, 12'd6);
        clr_pulse();
        chk("clr_err_hact", err_hact, 1'b0);
        line(H, 0, -1);
        line(H, 0, -1);

        // Frame of 5 lines: 5th line discarded and flagged at once.
        vsync_pulse();
        chk("f3_err_vact", err_vact, 1'b0);
        for (int l = 0; l < V; l++) line(H, 0, -1);
        k = d_words.size();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h60 + i));
        chk("line5_err_vact", err_vact, 1'b1);
        line(5, 8'h70, -1);
        chk("line5_words", d_words.size() - k, 0);
        clr_pulse();
        chk("clr_err_vact", err_vact, 1'b0);
        vsync_pulse();
        chk("f5l_err_vact", err_vact, 1'b1);
        chk("f5l_meas_v", meas_v, 12'd5);
        clr_pulse();

        // Frame of 3 lines: flagged at the following vsync.
        for (int l = 0; l < 3; l++) line(H, 0, -1);
        chk("f3l_err_vact_before", err_vact, 1'b0);
        vsync_pulse();
        chk("f3l_err_vact", err_vact, 1'b1);
        chk("f3l_meas_v", meas_v, 12'd3);
        clr_pulse();

        // Stalled output across two word completions.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hA0 + i));
        gap(3);
        chk("ovf_valid", out_valid, 1'b1);
        chk("ovf_held_word", out_pixel, 16'hA1A0);
        chk("ovf_err", err_ovf, 1'b1);
        k = d_words.size();
        out_ready = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        out_ready = 1'b0;
        gap(3);
        chk("ovf_handshakes", d_words.size() - k, 1);
        chk("ovf_taken_word", d_words[$], 16'hA1A0);
        chk("ovf_valid_after", out_valid, 1'b0);
        clr_pulse();

        // Reset mid-line while a word is pending.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hB0 + i));
        chk("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b1, 8'hB4);
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_pixel", out_pixel, 16'h0000);
        chk("mid_rst_fs", frame_start, 1'b0);
        chk("mid_rst_meas", {meas_h, meas_v}, 24'h000000);
        chk("mid_rst_errs", {err_hact, err_vact, err_ovf}, 3'b000);
        out_ready = 1'b1;
        step(1'b0, 1'b1, 8'hB5);
        gap(3);
        line(H, 0, -1);
        vsync_pulse();
        chk("post_rst_err_vact", err_vact, 1'b0);
        for (int l = 0; l < V; l++) line(H, 0, -1);
        vsync_pulse();
        chk("post_rst_f_err_vact", err_vact, 1'b0);
        chk("post_rst_meas_v", meas_v, 12'd4);

        // Randomized frames, ready, clears and the odd mid-line vsync.
        rand_mode = 1;
        for (int f = 0; f < 14; f++) begin
            vsync_pulse();
            gap($urandom_range(0, 3));
            nl = $urandom_range(3, 5);
            for (int l = 0; l < nl; l++) begin
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 9) : H;
                vs_at = ($urandom_range(0, 15) == 0) ? $urandom_range(0, len - 1) : -1;
                line(len, $urandom_range(0, 255), vs_at);
                gap($urandom_range(0, 2));
            end
        end
        rand_mode = 0;
        out_ready = 1'b1;
        err_clr = 1'b0;
        gap(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
